// File: rtl/indirect_target_cache.sv
// Indirect-jump target cache: tagged, direct-mapped, 2-bit confidence per entry.
// Trains on resolved JALR (non-return) jumps and returns a registered target
// prediction one cycle after a lookup. A flush sweeps the valid bits one entry
// per cycle.
//
// Handshake: ready_o is the single flow-control signal. Lookups and updates are
// accepted only in a cycle where ready_o is high; anything presented while it is
// low is dropped, never queued. There is no backpressure on the outputs.

package itc_pkg;
    localparam int VLEN = 32;

    typedef enum logic [2:0] {
        CF_NONE   = 3'd0,
        CF_BRANCH = 3'd1,
        CF_JUMP   = 3'd2,
        CF_JUMPR  = 3'd3,
        CF_RETURN = 3'd4
    } cf_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        logic            is_taken;
        cf_t             cf_type;
    } bp_resolve_t;
endpackage

module indirect_target_cache
    import itc_pkg::*;
#(
    parameter int NR_ENTRIES = 16,
    parameter int TAG_BITS   = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_bp_i,
    input  logic            debug_mode_i,
    input  bp_resolve_t     resolved_branch_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            ready_o,
    output logic            predict_valid_o,
    output logic [VLEN-1:0] predict_address_o
);

    localparam int IDX_BITS = $clog2(NR_ENTRIES);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Sweep FSM
    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] cnt_q, cnt_d;
    logic                clr_en;

    // Table storage; only the valid bits need a reset value
    logic [NR_ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0]   tag_q    [NR_ENTRIES];
    logic [VLEN-1:1]       target_q [NR_ENTRIES];
    logic [1:0]            conf_q   [NR_ENTRIES];

    // Lookup path
    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;
    logic                predict_valid_q, predict_valid_d;
    logic [VLEN-1:0]     predict_address_q, predict_address_d;

    // Update path
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0] up_tag;
    logic [VLEN-1:1]     up_target;
    logic                up_en;
    logic                up_hit;
    logic [VLEN-1:1]     wr_target_d;
    logic [1:0]          wr_conf_d;

    assign ready_o = (state_q == ST_IDLE) && !flush_bp_i;

    // Sweep state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep next-state: a new flush request always restarts the walk at entry 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_bp_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                clr_en = 1'b1;
                if (flush_bp_i) begin
                    cnt_d = '0;
                end else if (cnt_q == IDX_BITS'(NR_ENTRIES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Lookup: compare against the table as it stands this cycle (read-before-write)
    always_comb begin
        lk_idx            = lookup_pc_i[IDX_BITS:1];
        lk_tag            = lookup_pc_i[IDX_BITS+TAG_BITS:IDX_BITS+1];
        lk_hit            = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        predict_valid_d   = lookup_valid_i && ready_o && lk_hit;
        predict_address_d = predict_address_q;
        if (predict_valid_d) begin
            predict_address_d = {target_q[lk_idx], 1'b0};
        end
    end

    // Registered prediction outputs; the address holds on a miss
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            predict_valid_q   <= 1'b0;
            predict_address_q <= '0;
        end else begin
            predict_valid_q   <= predict_valid_d;
            predict_address_q <= predict_address_d;
        end
    end

    assign predict_valid_o   = predict_valid_q;
    assign predict_address_o = predict_address_q;

    // Update: allocate on miss, otherwise hysteresis on the 2-bit confidence
    always_comb begin
        up_idx      = resolved_branch_i.pc[IDX_BITS:1];
        up_tag      = resolved_branch_i.pc[IDX_BITS+TAG_BITS:IDX_BITS+1];
        up_target   = resolved_branch_i.target_address[VLEN-1:1];
        up_en       = resolved_branch_i.valid && (resolved_branch_i.cf_type == CF_JUMPR)
                      && !debug_mode_i && ready_o;
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        wr_target_d = up_target;
        wr_conf_d   = 2'd1;
        if (up_hit) begin
            if (target_q[up_idx] == up_target) begin
                wr_target_d = target_q[up_idx];
                wr_conf_d   = (conf_q[up_idx] == 2'd3) ? 2'd3 : conf_q[up_idx] + 2'd1;
            end else if (conf_q[up_idx] != 2'd0) begin
                wr_target_d = target_q[up_idx];
                wr_conf_d   = conf_q[up_idx] - 2'd1;
            end
        end
    end

    // Valid bits: set by allocation, cleared by the sweep (never in the same cycle)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            if (up_en) begin
                valid_q[up_idx] <= 1'b1;
            end
            if (clr_en) begin
                valid_q[cnt_q] <= 1'b0;
            end
        end
    end

    // Entry payload write
    always_ff @(posedge clk_i) begin
        if (up_en) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= wr_target_d;
            conf_q[up_idx]   <= wr_conf_d;
        end
    end

    // Bits of the resolution record that this table does not consume
    logic unused_bits;
    assign unused_bits = ^{resolved_branch_i.is_mispredict, resolved_branch_i.is_taken,
                           resolved_branch_i.pc[0], resolved_branch_i.pc[VLEN-1:IDX_BITS+TAG_BITS+1],
                           resolved_branch_i.target_address[0],
                           lookup_pc_i[0], lookup_pc_i[VLEN-1:IDX_BITS+TAG_BITS+1]};

endmodule
